systolic_seq_ctrl: RTL

Job sequencer for the 32x32 systolic matrix-multiply array. It accepts a job of 1-14 back-to-back tiles over a start/done handshake. It then drives the weight/data SRAM read ports, the array's `alu_start`, `cycle_num` and `matrix_index` controls, and a skewed result-valid stream to the result write-back logic. It sits between the layer-level scheduler and the array/SRAM bank pair.

---
 rtl/systolic_pkg.sv | 34 +++
 rtl/systolic_out_window.sv | 48 ++++
 rtl/systolic_seq_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and tile arithmetic for the systolic job sequencer.
package systolic_pkg;

  localparam int ARRAY_SIZE     = 32;
  localparam int FIRST_OUT      = 33;
  localparam int PARALLEL_START = 65;
  localparam int DIAG_MOD       = 64;
  localparam int MAX_TILES      = 14;

  localparam int CYCLE_W = 9;
  localparam int MIDX_W  = 6;
  localparam int TILES_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // cycle_num at which the last SRAM row of the job is presented to the array
  function automatic logic [CYCLE_W-1:0] last_feed_cycle(input logic [TILES_W-1:0] tiles,
                                                         input int array_size);
    return CYCLE_W'(int'(tiles) * array_size - 1);
  endfunction

  // the last row fed completes its final diagonal PARALLEL_START-1 cycles later
  function automatic logic [CYCLE_W-1:0] last_out_cycle(input logic [TILES_W-1:0] tiles,
                                                        input int array_size);
    return CYCLE_W'(int'(tiles) * array_size - 1 + PARALLEL_START - 1);
  endfunction

endpackage

// File: rtl/systolic_out_window.sv
// Result window: registers out_valid/first/last, matrix_index and out_waddr from the
// sequencer's next-cycle state, so they line up with the registered cycle_num.
module systolic_out_window
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 32,
  parameter int FIRST_OUT  = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  seq_state_t         state_nxt,
  input  logic [CYCLE_W-1:0] cycle_nxt,
  input  logic [TILES_W-1:0] tiles_nxt,
  output logic               out_valid,
  output logic               out_first,
  output logic               out_last,
  output logic [MIDX_W-1:0]  matrix_index,
  output logic [CYCLE_W-1:0] out_waddr
);

  logic [CYCLE_W-1:0] last_out;
  logic [CYCLE_W-1:0] offset;
  logic               active;
  logic               in_win;

  assign last_out = last_out_cycle(tiles_nxt, ARRAY_SIZE);
  assign active   = (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
  assign in_win   = active && (cycle_nxt >= CYCLE_W'(FIRST_OUT)) && (cycle_nxt <= last_out);
  assign offset   = cycle_nxt - CYCLE_W'(FIRST_OUT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
      matrix_index <= '0;
      out_waddr    <= '0;
    end else begin
      out_valid    <= in_win;
      out_first    <= in_win && (cycle_nxt == CYCLE_W'(FIRST_OUT));
      out_last     <= in_win && (cycle_nxt == last_out);
      // diagonal select cycles through the 64 diagonals; held at 0 outside the window
      matrix_index <= in_win ? MIDX_W'(offset % CYCLE_W'(DIAG_MOD)) : '0;
      out_waddr    <= in_win ? offset : '0;
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the systolic array: SRAM read pacing, array controls, result window.
// Optional build macro SYSTOLIC_CTRL_PERF_EN adds the perf_jobs/perf_active counters.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = systolic_pkg::ARRAY_SIZE,
  parameter int ADDR_WIDTH = 9,
  parameter int FIRST_OUT  = systolic_pkg::FIRST_OUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            num_tiles,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  output logic                  feed_zero,
  output logic                  alu_start,
  output logic [8:0]            cycle_num,
  output logic [5:0]            matrix_index,
  output logic                  out_valid,
  output logic                  out_first,
  output logic                  out_last,
  output logic [8:0]            out_waddr,
  output logic [2:0]            dbg_state
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [15:0]           perf_jobs,
  output logic [31:0]           perf_active
`endif
);

  // Handshake: start is sampled only in IDLE; an accepted start raises busy on the next
  // cycle, and done pulses for one cycle (busy still high) before returning to IDLE.

  seq_state_t              state_q, state_d;
  logic [TILES_W-1:0]      tiles_q, tiles_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   raddr_d;
  logic [CYCLE_W-1:0]      cycle_d;
  logic [CYCLE_W-1:0]      last_feed;
  logic [CYCLE_W-1:0]      last_out;
  logic                    busy_d, done_d, cfg_err_d, ren_d, feed_zero_d, alu_d;
  logic                    num_ok;

  assign num_ok    = (num_tiles != '0) && (num_tiles <= TILES_W'(MAX_TILES));
  assign last_feed = last_feed_cycle(tiles_q, ARRAY_SIZE);
  assign last_out  = last_out_cycle(tiles_q, ARRAY_SIZE);
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    tiles_d     = tiles_q;
    base_d      = base_q;
    cycle_d     = '0;
    raddr_d     = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    ren_d       = 1'b0;
    feed_zero_d = 1'b0;
    alu_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_ok) begin
            state_d = ST_PRELOAD;
            tiles_d = num_tiles;
            base_d  = base_addr;
            busy_d  = 1'b1;
            ren_d   = 1'b1;
            raddr_d = base_addr;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_PRELOAD: begin
        // the row read during PRELOAD arrives with cycle_num 0
        state_d = ST_RUN;
        busy_d  = 1'b1;
        alu_d   = 1'b1;
        cycle_d = '0;
        ren_d   = 1'b1;
        raddr_d = base_q + ADDR_WIDTH'(1);
      end
      ST_RUN: begin
        busy_d  = 1'b1;
        alu_d   = 1'b1;
        cycle_d = cycle_num + 1'b1;
        if (cycle_num == last_feed) begin
          state_d     = ST_DRAIN;
          feed_zero_d = 1'b1;
        end else begin
          ren_d   = (cycle_d < last_feed);
          raddr_d = ren_d ? base_q + ADDR_WIDTH'(cycle_d) + ADDR_WIDTH'(1) : '0;
        end
      end
      ST_DRAIN: begin
        busy_d = 1'b1;
        if (cycle_num == last_out) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          alu_d       = 1'b1;
          feed_zero_d = 1'b1;
          cycle_d     = cycle_num + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tiles_q    <= '0;
      base_q     <= '0;
      cycle_num  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      sram_ren   <= 1'b0;
      sram_raddr <= '0;
      feed_zero  <= 1'b0;
      alu_start  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tiles_q    <= tiles_d;
      base_q     <= base_d;
      cycle_num  <= cycle_d;
      busy       <= busy_d;
      done       <= done_d;
      cfg_err    <= cfg_err_d;
      sram_ren   <= ren_d;
      sram_raddr <= raddr_d;
      feed_zero  <= feed_zero_d;
      alu_start  <= alu_d;
    end
  end

  systolic_out_window #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .FIRST_OUT  (FIRST_OUT)
  ) u_out_window (
    .clk          (clk),
    .rst_n        (rst_n),
    .state_nxt    (state_d),
    .cycle_nxt    (cycle_d),
    .tiles_nxt    (tiles_d),
    .out_valid    (out_valid),
    .out_first    (out_first),
    .out_last     (out_last),
    .matrix_index (matrix_index),
    .out_waddr    (out_waddr)
  );

`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_jobs   <= '0;
      perf_active <= '0;
    end else begin
      if (done && (perf_jobs != '1)) begin
        perf_jobs <= perf_jobs + 16'd1;
      end
      if (alu_start && (perf_active != '1)) begin
        perf_active <= perf_active + 32'd1;
      end
    end
  end
`endif

endmodule
